imem_loader: RTL and testbench

//  Write-side counterpart to the byte-addressed instruction memory. Accepts 32-bit

---
 rtl/imem_loader.sv | 137 +++++++++++++
 tb/tb_imem_loader.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Streams 32-bit words into byte-addressed imem as four little-endian byte writes.
// Latency: start->word_ready 1 cycle; handshake->writes in the following 4 cycles; 1 word per 5 cycles peak.
// Backpressure: word_ready is high only in ACCEPT; a stalled producer holds the loader there indefinitely.
module imem_loader #(
    parameter int MEM_BYTES = 208,
    parameter int ADDR_W    = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              word_valid,
    output logic              word_ready,
    input  logic [31:0]       word_data,
    input  logic              word_last,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_byte,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        S_IDLE, S_ACCEPT, S_WR0, S_WR1, S_WR2, S_WR3, S_DONE
    } state_t;

    // Highest legal byte address, one bit wider than ptr so ptr+3 cannot wrap past the check.
    localparam logic [ADDR_W:0] LAST_ADDR = (ADDR_W+1)'(MEM_BYTES - 1);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] ptr, ptr_nxt;
    logic [31:0]       word, word_nxt;
    logic              last, last_nxt;
    logic              err_nxt;
    logic [ADDR_W:0]   end_addr;

    logic              ready_nxt, wr_en_nxt, hold_nxt, done_nxt;
    logic [1:0]        k_nxt;
    logic [ADDR_W-1:0] wr_addr_nxt;
    logic [7:0]        wr_byte_nxt;

    assign end_addr = {1'b0, ptr} + (ADDR_W+1)'(3);

    // Next-state, datapath updates and next values of the registered outputs.
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        word_nxt  = word;
        last_nxt  = last;
        err_nxt   = err;
        case (state)
            S_IDLE: begin
                if (start) begin
                    ptr_nxt = base_addr;
                    err_nxt = 1'b0;
                    if (base_addr[1:0] != 2'b00) begin
                        err_nxt   = 1'b1;
                        state_nxt = S_DONE;
                    end else begin
                        state_nxt = S_ACCEPT;
                    end
                end
            end
            S_ACCEPT: begin
                if (word_valid) begin
                    word_nxt = word_data;
                    last_nxt = word_last;
                    if (end_addr > LAST_ADDR) begin
                        err_nxt   = 1'b1;
                        state_nxt = S_DONE;
                    end else begin
                        state_nxt = S_WR0;
                    end
                end
            end
            S_WR0: state_nxt = S_WR1;
            S_WR1: state_nxt = S_WR2;
            S_WR2: state_nxt = S_WR3;
            S_WR3: begin
                ptr_nxt   = ptr + ADDR_W'(4);
                state_nxt = last ? S_DONE : S_ACCEPT;
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase

        // Outputs are decoded from the upcoming state so they can be registered.
        ready_nxt = (state_nxt == S_ACCEPT);
        hold_nxt  = (state_nxt != S_IDLE);
        done_nxt  = (state_nxt == S_DONE);
        wr_en_nxt = 1'b1;
        k_nxt     = 2'd0;
        case (state_nxt)
            S_WR0:   k_nxt = 2'd0;
            S_WR1:   k_nxt = 2'd1;
            S_WR2:   k_nxt = 2'd2;
            S_WR3:   k_nxt = 2'd3;
            default: wr_en_nxt = 1'b0;
        endcase
        wr_addr_nxt = wr_en_nxt ? (ptr_nxt + ADDR_W'(k_nxt)) : '0;
        wr_byte_nxt = wr_en_nxt ? word_nxt[{k_nxt, 3'b000} +: 8] : 8'h00;
    end

    // State, datapath and output registers; reset abandons any session in progress.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            ptr        <= '0;
            word       <= '0;
            last       <= 1'b0;
            err        <= 1'b0;
            word_ready <= 1'b0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_byte    <= '0;
            cpu_hold   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_nxt;
            ptr        <= ptr_nxt;
            word       <= word_nxt;
            last       <= last_nxt;
            err        <= err_nxt;
            word_ready <= ready_nxt;
            wr_en      <= wr_en_nxt;
            wr_addr    <= wr_addr_nxt;
            wr_byte    <= wr_byte_nxt;
            cpu_hold   <= hold_nxt;
            busy       <= hold_nxt;
            done       <= done_nxt;
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: cycle table for a two-word load plus hand sequences.
// Inputs change 1ns after the rising edge; outputs are read at the same point.
// A byte-array model of imem captures every write for readback checks.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [63:0] base_addr;
    logic        word_valid;
    logic        word_ready;
    logic [31:0] word_data;
    logic        word_last;
    logic        wr_en;
    logic [63:0] wr_addr;
    logic [7:0]  wr_byte;
    logic        cpu_hold;
    logic        busy;
    logic        done;
    logic        err;

    imem_loader #(.MEM_BYTES(208), .ADDR_W(64)) dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
        .word_valid(word_valid), .word_ready(word_ready), .word_data(word_data),
        .word_last(word_last), .wr_en(wr_en), .wr_addr(wr_addr), .wr_byte(wr_byte),
        .cpu_hold(cpu_hold), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int       tests = 0;
    int       fails = 0;
    int       wr_count = 0;
    logic [7:0] mem [208];

    // imem model: commits the byte presented in each write cycle
    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            wr_count++;
            if (wr_addr < 64'd208) mem[int'(wr_addr[7:0])] = wr_byte;
        end
    end

    typedef struct {
        logic        start;
        logic [63:0] base;
        logic        valid;
        logic [31:0] data;
        logic        last;
        logic [77:0] exp;
    } vec_t;

    function automatic logic [77:0] pk(logic rdy, logic en, logic [63:0] a, logic [7:0] b,
                                       logic hold, logic dn, logic er);
        return {rdy, en, a, b, hold, hold, dn, er};
    endfunction

    function automatic logic [77:0] obs();
        return {word_ready, wr_en, wr_addr, wr_byte, cpu_hold, busy, done, err};
    endfunction

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a word and hold it until it is accepted (bounded).
    task automatic do_word(input logic [31:0] d, input logic l, input string name);
        bit ok = 0;
        word_valid = 1'b1; word_data = d; word_last = l;
        for (int i = 0; i < 30; i++) begin
            if (word_ready) begin ok = 1; step(); break; end
            step();
        end
        word_valid = 1'b0;
        check({name, "_accept"}, 128'(ok), 128'(1));
    endtask

    // Wait (bounded) for the done pulse and report err sampled alongside it.
    task automatic wait_done(input string name, output logic err_at_done);
        bit ok = 0;
        err_at_done = 1'bx;
        for (int i = 0; i < 30; i++) begin
            if (done) begin ok = 1; err_at_done = err; step(); break; end
            step();
        end
        check({name, "_done"}, 128'(ok), 128'(1));
    endtask

    vec_t tbl [13];
    logic e;

    initial begin
        for (int i = 0; i < 208; i++) mem[i] = 8'h00;
        reset = 1'b1; start = 1'b0; base_addr = '0;
        word_valid = 1'b0; word_data = '0; word_last = 1'b0;
        step(); step();
        check("reset_outputs", 128'(obs()), 128'(0));
        reset = 1'b0;

        // T1: two words from address 0, valid held high throughout
        tbl[0]  = '{1'b1, 64'd0, 1'b0, 32'h0, 1'b0, pk(0, 0, 0, 8'h00, 0, 0, 0)};
        tbl[1]  = '{1'b0, 64'd0, 1'b1, 32'h00000513, 1'b0, pk(1, 0, 0, 8'h00, 1, 0, 0)};
        tbl[2]  = '{1'b0, 64'd0, 1'b1, 32'h00100293, 1'b1, pk(0, 1, 0, 8'h13, 1, 0, 0)};
        tbl[3]  = '{1'b0, 64'd0, 1'b1, 32'h00100293, 1'b1, pk(0, 1, 1, 8'h05, 1, 0, 0)};
        tbl[4]  = '{1'b0, 64'd0, 1'b1, 32'h00100293, 1'b1, pk(0, 1, 2, 8'h00, 1, 0, 0)};
        tbl[5]  = '{1'b0, 64'd0, 1'b1, 32'h00100293, 1'b1, pk(0, 1, 3, 8'h00, 1, 0, 0)};
        tbl[6]  = '{1'b0, 64'd0, 1'b1, 32'h00100293, 1'b1, pk(1, 0, 0, 8'h00, 1, 0, 0)};
        tbl[7]  = '{1'b0, 64'd0, 1'b0, 32'h0, 1'b0, pk(0, 1, 4, 8'h93, 1, 0, 0)};
        tbl[8]  = '{1'b0, 64'd0, 1'b0, 32'h0, 1'b0, pk(0, 1, 5, 8'h02, 1, 0, 0)};
        tbl[9]  = '{1'b0, 64'd0, 1'b0, 32'h0, 1'b0, pk(0, 1, 6, 8'h10, 1, 0, 0)};
        tbl[10] = '{1'b0, 64'd0, 1'b0, 32'h0, 1'b0, pk(0, 1, 7, 8'h00, 1, 0, 0)};
        tbl[11] = '{1'b0, 64'd0, 1'b0, 32'h0, 1'b0, pk(0, 0, 0, 8'h00, 1, 1, 0)};
        tbl[12] = '{1'b0, 64'd0, 1'b0, 32'h0, 1'b0, pk(0, 0, 0, 8'h00, 0, 0, 0)};
        for (int i = 0; i < 13; i++) begin
            start = tbl[i].start; base_addr = tbl[i].base;
            word_valid = tbl[i].valid; word_data = tbl[i].data; word_last = tbl[i].last;
            check($sformatf("t1_cycle%0d", i), 128'(obs()), 128'(tbl[i].exp));
            step();
        end

        // T2: readback of the loaded words
        check("t2_word0", 128'({mem[3], mem[2], mem[1], mem[0]}), 128'(32'h00000513));
        check("t2_word4", 128'({mem[7], mem[6], mem[5], mem[4]}), 128'(32'h00100293));

        // T3: second word would overrun the memory end
        wr_count = 0;
        start = 1'b1; base_addr = 64'd204; step(); start = 1'b0;
        do_word(32'hDDCCBBAA, 1'b0, "t3_w0");
        do_word(32'h01020304, 1'b1, "t3_w1");
        wait_done("t3", e);
        check("t3_err", 128'(e), 128'(1));
        check("t3_writes", 128'(wr_count), 128'(4));
        check("t3_bytes", 128'({mem[207], mem[206], mem[205], mem[204]}), 128'(32'hDDCCBBAA));

        // T4: misaligned base
        step();
        wr_count = 0;
        start = 1'b1; base_addr = 64'h6; step(); start = 1'b0;
        check("t4_done_cycle", 128'({word_ready, done, err, cpu_hold}), 128'(4'b0111));
        step();
        check("t4_after", 128'({word_ready, done, err, cpu_hold}), 128'(4'b0010));
        check("t4_writes", 128'(wr_count), 128'(0));

        // T5: producer stall of 7 cycles, stray start during WR1
        wr_count = 0;
        start = 1'b1; base_addr = 64'd16; step(); start = 1'b0;
        check("t5_err_cleared", 128'(err), 128'(0));
        for (int i = 0; i < 7; i++) begin
            check($sformatf("t5_stall%0d", i), 128'({word_ready, wr_en}), 128'(2'b10));
            step();
        end
        word_valid = 1'b1; word_data = 32'h11223344; word_last = 1'b0;
        step(); word_valid = 1'b0;
        step();
        start = 1'b1; base_addr = 64'd100;
        check("t5_wr1", 128'({wr_en, wr_addr, wr_byte}), 128'({1'b1, 64'd17, 8'h33}));
        step(); start = 1'b0;
        do_word(32'h55667788, 1'b1, "t5_w1");
        wait_done("t5", e);
        check("t5_err", 128'(e), 128'(0));
        check("t5_writes", 128'(wr_count), 128'(8));
        check("t5_bytes", 128'({mem[23], mem[22], mem[21], mem[20], mem[19], mem[18], mem[17], mem[16]}),
              128'(64'h5566778811223344));
        check("t5_no_stray", 128'(mem[100]), 128'(0));

        // T6: reset in WR2 abandons the session
        step();
        start = 1'b1; base_addr = 64'd0; step(); start = 1'b0;
        word_valid = 1'b1; word_data = 32'hA5B6C7D8; word_last = 1'b1;
        step(); word_valid = 1'b0;
        step(); step();
        check("t6_in_wr2", 128'({wr_en, wr_addr}), 128'({1'b1, 64'd2}));
        reset = 1'b1; step(); reset = 1'b0;
        check("t6_reset_outputs", 128'(obs()), 128'(0));
        check("t6_retained", 128'({mem[1], mem[0]}), 128'(16'hC7D8));
        step();
        wr_count = 0;
        start = 1'b1; base_addr = 64'd8; step(); start = 1'b0;
        do_word(32'h0BADF00D, 1'b1, "t6_w0");
        wait_done("t6", e);
        check("t6_err", 128'(e), 128'(0));
        check("t6_bytes", 128'({mem[11], mem[10], mem[9], mem[8]}), 128'(32'h0BADF00D));
        check("t6_writes", 128'(wr_count), 128'(4));
        check("t6_idle", 128'(obs()), 128'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
